// File: rtl/arb_pkg.sv
// Shared types and helpers for the registered request arbiter.
package arb_pkg;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
    typedef enum logic {IDLE, GRANTED} arb_state_e;

    // Index increment with wrap at n; works for non-power-of-2 requester counts.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: highest index (fixed) or first set index from ptr (rotating).
module arb_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        idx   = '0;
        pos   = '0;
        valid = |req;
        if (mode == ARB_FIXED) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest set bit wins last.
            for (int k = N_REQ - 1; k >= 0; k--) begin
                pos = IDX_W'((int'(ptr) + k) % N_REQ);
                if (req[pos]) idx = pos;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin, grant locked until release,
// with an optional hold limit that forces a hand-off.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int        N_REQ    = 4,
    parameter int        IDX_W    = $clog2(N_REQ),
    parameter arb_mode_e MODE     = ARB_RR,
    parameter int        MAX_HOLD = 0,
    parameter int        HOLD_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             release_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    if (N_REQ < 2) begin : g_chk_n_req
        $error("rr_arbiter: N_REQ must be >= 2");
    end
    if (MAX_HOLD < 0 || longint'(MAX_HOLD) >= (longint'(1) << HOLD_W)) begin : g_chk_hold
        $error("rr_arbiter: MAX_HOLD must fit in HOLD_W bits");
    end

    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    // Handshake: req_i is a level held by a requester until it is served; the owner ends its
    // tenure with a 1-cycle release_i strobe or by dropping its request. release_i is
    // ignored while no grant is active.
    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt, ptr_inc, pick_ptr, pick_idx, idx_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [N_REQ-1:0]  owner_mask, pick_req;
    logic              pick_valid, valid_nxt, timeout_nxt;
    logic              owner_drop, hold_hit, end_grant;

    assign ptr_inc    = IDX_W'(wrap_inc(int'(gnt_idx_o), N_REQ));
    assign owner_mask = N_REQ'(1) << gnt_idx_o;
    assign owner_drop = (req_i & owner_mask) == '0;
    assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign end_grant  = (state == GRANTED) && (release_i || owner_drop || hold_hit);

    // On hand-off the outgoing owner is masked and the search starts just past it.
    assign pick_req = (state == GRANTED) ? (req_i & ~owner_mask) : req_i;
    assign pick_ptr = (state == GRANTED && MODE == ARB_RR) ? ptr_inc : ptr;

    arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .mode  (MODE),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            gnt_o       <= valid_nxt ? (N_REQ'(1) << idx_nxt) : '0;
            gnt_idx_o   <= idx_nxt;
            gnt_valid_o <= valid_nxt;
            timeout_o   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = GRANTED;
            GRANTED: if (end_grant && !pick_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_nxt     = gnt_idx_o;
        valid_nxt   = gnt_valid_o;
        ptr_nxt     = ptr;
        timeout_nxt = 1'b0;
        hold_nxt    = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
        if (state == IDLE || end_grant) begin
            idx_nxt   = pick_valid ? pick_idx : '0;
            valid_nxt = pick_valid;
            hold_nxt  = '0;
        end
        if (end_grant) begin
            if (MODE == ARB_RR) ptr_nxt = ptr_inc;
            // An explicit or implicit release at the same edge is not a timeout.
            timeout_nxt = hold_hit && !release_i && !owner_drop;
        end
    end

endmodule
